// File: rtl/fetch_unit.sv
// Instruction fetch stage and IF/ID register: one outstanding request, one-entry stall buffer,
// drop of in-flight responses on redirect. Optional macro FETCH_FLUSH_NOP_EN makes flush write a NOP.
module fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     StallF,
    input  logic                     StallD,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    output logic                     IMemReq,
    output logic [ADDRESS_WIDTH-1:0] IMemAddr,
    input  logic                     IMemGnt,
    input  logic                     IMemRValid,
    input  logic [ADDRESS_WIDTH-1:0] IMemRData,
    output logic [ADDRESS_WIDTH-1:0] InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD
);

    localparam logic [ADDRESS_WIDTH-1:0] NOP_INSTR = ADDRESS_WIDTH'(32'h0000_0013);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = ADDRESS_WIDTH'(4);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] pc_reg, pc_next;
    logic [ADDRESS_WIDTH-1:0] req_pc_reg, req_pc_next;
    logic                     buf_valid_reg, buf_valid_next;
    logic [ADDRESS_WIDTH-1:0] buf_instr_reg, buf_instr_next;
    logic [ADDRESS_WIDTH-1:0] buf_pc_reg, buf_pc_next;
    logic                     valid_d_reg, valid_d_next;
    logic [ADDRESS_WIDTH-1:0] instr_d_reg, instr_d_next;
    logic [ADDRESS_WIDTH-1:0] pc_d_reg, pc_d_next;
    logic [ADDRESS_WIDTH-1:0] pc_plus4_d_reg, pc_plus4_d_next;

    logic issue;
    logic req;
    logic grant;
    logic deliver;

    // Request/next-state logic; IMemGnt only steers the next state, never IMemReq itself.
    always_comb begin
        issue      = !StallF && !buf_valid_reg && !PCSrcE;
        req        = 1'b0;
        state_next = state_reg;
        case (state_reg)
            REQ: begin
                req = issue;
                if (issue && IMemGnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (PCSrcE) begin
                    state_next = IMemRValid ? REQ : DROP;
                end else if (IMemRValid) begin
                    req        = issue;
                    state_next = (issue && IMemGnt) ? WAIT : REQ;
                end
            end
            DROP: begin
                if (IMemRValid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
        if (!rst_n) begin
            req = 1'b0;
        end
    end

    assign grant    = req && IMemGnt;
    assign deliver  = (state_reg == WAIT) && IMemRValid && !PCSrcE;
    assign IMemReq  = req;
    assign IMemAddr = pc_reg;

    always_comb begin
        pc_next         = pc_reg;
        req_pc_next     = req_pc_reg;
        buf_valid_next  = buf_valid_reg;
        buf_instr_next  = buf_instr_reg;
        buf_pc_next     = buf_pc_reg;
        valid_d_next    = valid_d_reg;
        instr_d_next    = instr_d_reg;
        pc_d_next       = pc_d_reg;
        pc_plus4_d_next = pc_plus4_d_reg;

        if (PCSrcE) begin
            pc_next = PCTargetE;
        end else if (grant) begin
            pc_next = pc_reg + PC_STEP;
        end
        if (grant) begin
            req_pc_next = pc_reg;
        end

        // The buffer only fills while decode is stalled; it drains into IF/ID once the stall lifts.
        if (PCSrcE) begin
            buf_valid_next = 1'b0;
        end else if (deliver && StallD) begin
            buf_valid_next = 1'b1;
            buf_instr_next = IMemRData;
            buf_pc_next    = req_pc_reg;
        end else if (buf_valid_reg && !StallD) begin
            buf_valid_next = 1'b0;
        end

        if (FlushD) begin
            valid_d_next = 1'b0;
`ifdef FETCH_FLUSH_NOP_EN
            instr_d_next    = NOP_INSTR;
            pc_d_next       = '0;
            pc_plus4_d_next = '0;
`endif
        end else if (!StallD) begin
            if (buf_valid_reg) begin
                valid_d_next    = 1'b1;
                instr_d_next    = buf_instr_reg;
                pc_d_next       = buf_pc_reg;
                pc_plus4_d_next = buf_pc_reg + PC_STEP;
            end else if (deliver) begin
                valid_d_next    = 1'b1;
                instr_d_next    = IMemRData;
                pc_d_next       = req_pc_reg;
                pc_plus4_d_next = req_pc_reg + PC_STEP;
            end else begin
                // Nothing arrived for an unstalled decode stage: present a bubble.
                valid_d_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= REQ;
            pc_reg         <= RESET_PC;
            req_pc_reg     <= RESET_PC;
            buf_valid_reg  <= 1'b0;
            buf_instr_reg  <= NOP_INSTR;
            buf_pc_reg     <= '0;
            valid_d_reg    <= 1'b0;
            instr_d_reg    <= NOP_INSTR;
            pc_d_reg       <= '0;
            pc_plus4_d_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_pc_reg     <= req_pc_next;
            buf_valid_reg  <= buf_valid_next;
            buf_instr_reg  <= buf_instr_next;
            buf_pc_reg     <= buf_pc_next;
            valid_d_reg    <= valid_d_next;
            instr_d_reg    <= instr_d_next;
            pc_d_reg       <= pc_d_next;
            pc_plus4_d_reg <= pc_plus4_d_next;
        end
    end

    assign InstrD   = instr_d_reg;
    assign PCD      = pc_d_reg;
    assign PCPlus4D = pc_plus4_d_reg;
    assign ValidD   = valid_d_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bench acts as instruction memory and hazard unit, cycle by cycle.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int vec_count  = 0;
    int miscompares = 0;

    fetch_unit #(
        .ADDRESS_WIDTH(32),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (stall_f),
        .StallD    (stall_d),
        .FlushD    (flush_d),
        .PCSrcE    (pc_src_e),
        .PCTargetE (pc_target_e),
        .IMemReq   (imem_req),
        .IMemAddr  (imem_addr),
        .IMemGnt   (imem_gnt),
        .IMemRValid(imem_rvalid),
        .IMemRData (imem_rdata),
        .InstrD    (instr_d),
        .PCD       (pc_d),
        .PCPlus4D  (pc_plus4_d),
        .ValidD    (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic ps,
                         input logic [31:0] tgt, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fd;
        pc_src_e    = ps;
        pc_target_e = tgt;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        tick();
        check_vec("rst_req", {31'd0, imem_req}, 32'd0);
        check_vec("rst_valid", {31'd0, valid_d}, 32'd0);
        check_vec("rst_instr", instr_d, 32'h0000_0013);
        check_vec("rst_pcd", pc_d, 32'h0);
        check_vec("rst_pcp4", pc_plus4_d, 32'h0);

        // Basic fetch with 1-cycle memory and early issue
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("c0_req", {31'd0, imem_req}, 32'd1);
        check_vec("c0_addr", imem_addr, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 1, 1, 32'h0050_0093);
        check_vec("c1_early_req", {31'd0, imem_req}, 32'd1);
        check_vec("c1_addr", imem_addr, 32'h4);
        tick();
        check_vec("c2_instr", instr_d, 32'h0050_0093);
        check_vec("c2_pcd", pc_d, 32'h0);
        check_vec("c2_pcp4", pc_plus4_d, 32'h4);
        check_vec("c2_valid", {31'd0, valid_d}, 32'd1);

        // Response during decode stall lands in the buffer
        drive(1, 1, 0, 0, 32'h0, 0, 1, 32'h00A0_0113);
        check_vec("buf_wr_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_vec("stall1_instr", instr_d, 32'h0050_0093);
        drive(0, 1, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("buf_req1", {31'd0, imem_req}, 32'd0);
        tick();
        check_vec("stall2_instr", instr_d, 32'h0050_0093);
        drive(0, 1, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("buf_req2", {31'd0, imem_req}, 32'd0);
        tick();
        check_vec("stall3_instr", instr_d, 32'h0050_0093);
        drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("buf_req3", {31'd0, imem_req}, 32'd0);
        tick();
        check_vec("drain_instr", instr_d, 32'h00A0_0113);
        check_vec("drain_pcd", pc_d, 32'h4);
        check_vec("drain_pcp4", pc_plus4_d, 32'h8);
        check_vec("drain_valid", {31'd0, valid_d}, 32'd1);

        // Redirect in WAIT, response arrives later and is dropped
        drive(0, 1, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("pre_redir_req", {31'd0, imem_req}, 32'd1);
        check_vec("pre_redir_addr", imem_addr, 32'h8);
        tick();
        drive(0, 1, 0, 1, 32'h100, 1, 0, 32'h0);
        check_vec("redir_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(0, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        check_vec("drop_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(0, 1, 0, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        check_vec("drop_rv_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_vec("drop_valid", {31'd0, valid_d}, 32'd1);
        check_vec("drop_instr", instr_d, 32'h00A0_0113);
        drive(0, 1, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("tgt_req", {31'd0, imem_req}, 32'd1);
        check_vec("tgt_addr", imem_addr, 32'h100);
        tick();

        // Redirect and response in the same WAIT cycle
        drive(0, 0, 0, 1, 32'h200, 1, 1, 32'h1111_1111);
        check_vec("same_req", {31'd0, imem_req}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("same_next_req", {31'd0, imem_req}, 32'd1);
        check_vec("same_next_addr", imem_addr, 32'h200);
        check_vec("same_instr", instr_d, 32'h00A0_0113);
        tick();
        drive(1, 0, 0, 0, 32'h0, 0, 1, 32'h0030_0193);
        tick();
        check_vec("ld3_instr", instr_d, 32'h0030_0193);
        check_vec("ld3_pcd", pc_d, 32'h200);
        check_vec("ld3_pcp4", pc_plus4_d, 32'h204);
        check_vec("ld3_valid", {31'd0, valid_d}, 32'd1);

        // Flush beats stall
        drive(1, 1, 1, 0, 32'h0, 0, 0, 32'h0);
        tick();
        check_vec("flush_valid", {31'd0, valid_d}, 32'd0);
`ifdef FETCH_FLUSH_NOP_EN
        check_vec("flush_instr", instr_d, 32'h0000_0013);
        check_vec("flush_pcd", pc_d, 32'h0);
`else
        check_vec("flush_instr", instr_d, 32'h0030_0193);
        check_vec("flush_pcd", pc_d, 32'h200);
`endif

        // Asynchronous reset while a request is outstanding
        drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("pre_rst_addr", imem_addr, 32'h204);
        tick();
        drive(0, 0, 0, 0, 32'h0, 1, 1, 32'h0040_0213);
        tick();
        check_vec("pre_rst_instr", instr_d, 32'h0040_0213);
        check_vec("pre_rst_pcd", pc_d, 32'h204);
        drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        check_vec("arst_valid", {31'd0, valid_d}, 32'd0);
        check_vec("arst_instr", instr_d, 32'h0000_0013);
        check_vec("arst_pcd", pc_d, 32'h0);
        check_vec("arst_pcp4", pc_plus4_d, 32'h0);
        check_vec("arst_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_vec("post_rst_req", {31'd0, imem_req}, 32'd1);
        check_vec("post_rst_addr", imem_addr, 32'h0);

        // PC wrap at the top of the address space
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        check_vec("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0033);
        check_vec("wrap_next_addr", imem_addr, 32'h0);
        check_vec("wrap_next_req", {31'd0, imem_req}, 32'd1);
        tick();
        check_vec("wrap_pcd", pc_d, 32'hFFFF_FFFC);
        check_vec("wrap_pcp4", pc_plus4_d, 32'h0);
        check_vec("wrap_instr", instr_d, 32'h0000_0033);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
